// File: rtl/instr_fetch_rv_if.sv
// Fetch-stage bus: instruction-memory req/ack channel plus the decode-side
// instruction/redirect channel. master = fetch stage, slave = memory + decode.
interface instr_fetch_rv_if;
  logic        orImemReq;
  logic [31:0] orImemAddr;
  logic        iwImemAck;
  logic [31:0] iwImemData;
  logic [31:0] orInstr;
  logic [31:0] orPc;
  logic        orInstrValid;
  logic        iwAdvance;
  logic [1:0]  iwNextPcSrc;
  logic [19:0] iwNextPcImmediate20;
  logic [11:0] iwNextPcImmediate12;
  logic [31:0] iwJalrBase;
  logic        iwBranchTaken;
  logic        orFault;

  modport master (
    output orImemReq, orImemAddr, orInstr, orPc, orInstrValid, orFault,
    input  iwImemAck, iwImemData, iwAdvance, iwNextPcSrc,
           iwNextPcImmediate20, iwNextPcImmediate12, iwJalrBase, iwBranchTaken
  );

  modport slave (
    input  orImemReq, orImemAddr, orInstr, orPc, orInstrValid, orFault,
    output iwImemAck, iwImemData, iwAdvance, iwNextPcSrc,
           iwNextPcImmediate20, iwNextPcImmediate12, iwJalrBase, iwBranchTaken
  );
endinterface

// File: rtl/instr_fetch_rv.sv
// RV32I fetch stage: holds the PC, fetches one word per req/ack handshake,
// presents it to decode and computes the next PC on advance.
module instr_fetch_rv #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic             iwClk,
  input logic             iwRst,
  instr_fetch_rv_if.master bus
);

  localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
  localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd1;
  localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd2;
  localparam logic [1:0] NEXT_PC_SRC_B    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        valid;
  logic        fault;

  logic [31:0] jal_off;
  logic [31:0] b_off;
  logic [31:0] jalr_sum;
  logic [31:0] npc;

  // Immediates arrive as raw instruction bit fields and are unscrambled here.
  always_comb begin
    jal_off  = {{11{bus.iwNextPcImmediate20[19]}}, bus.iwNextPcImmediate20[19],
                bus.iwNextPcImmediate20[7:0], bus.iwNextPcImmediate20[8],
                bus.iwNextPcImmediate20[18:9], 1'b0};
    b_off    = {{19{bus.iwNextPcImmediate12[11]}}, bus.iwNextPcImmediate12[11],
                bus.iwNextPcImmediate12[0], bus.iwNextPcImmediate12[10:5],
                bus.iwNextPcImmediate12[4:1], 1'b0};
    jalr_sum = bus.iwJalrBase + {{20{bus.iwNextPcImmediate12[11]}}, bus.iwNextPcImmediate12};
    npc      = pc + 32'd4;
    case (bus.iwNextPcSrc)
      NEXT_PC_SRC_SEQ:  npc = pc + 32'd4;
      NEXT_PC_SRC_JAL:  npc = pc + jal_off;
      NEXT_PC_SRC_JALR: npc = {jalr_sum[31:1], 1'b0};
      NEXT_PC_SRC_B:    npc = bus.iwBranchTaken ? (pc + b_off) : (pc + 32'd4);
      default:          npc = pc + 32'd4;
    endcase
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req      <= 1'b0;
      addr     <= RESET_PC;
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
      valid    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req   <= 1'b1;
          addr  <= pc;
        end
        S_REQ: begin
          if (bus.iwImemAck) begin
            instr    <= bus.iwImemData;
            instr_pc <= pc;
            valid    <= 1'b1;
            req      <= 1'b0;
            state    <= S_VALID;
          end
        end
        S_VALID: begin
          if (bus.iwAdvance) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            if (npc[1:0] != 2'b00) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end else begin
              pc    <= npc;
              req   <= 1'b1;
              addr  <= npc;
              state <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          // Terminal until reset.
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.orImemReq    = req;
  assign bus.orImemAddr   = addr;
  assign bus.orInstr      = instr;
  assign bus.orPc         = instr_pc;
  assign bus.orInstrValid = valid;
  assign bus.orFault      = fault;

endmodule

// File: tb/tb_instr_fetch_rv.sv
// Bench for instr_fetch_rv: directed redirect table, reset corner cases and a
// randomized run against an arithmetic next-PC model.
module tb_instr_fetch_rv;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_rv_if bus ();

  instr_fetch_rv #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .iwClk(clk),
    .iwRst(rst),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  src;
    logic [19:0] i20;
    logic [11:0] i12;
    logic [31:0] base;
    logic        taken;
    logic [31:0] exp_addr;
    logic        exp_fault;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic scramble();
    bus.iwNextPcSrc         = 2'($urandom);
    bus.iwNextPcImmediate20 = 20'($urandom);
    bus.iwNextPcImmediate12 = 12'($urandom);
    bus.iwJalrBase          = $urandom;
    bus.iwBranchTaken       = 1'($urandom);
  endtask

  // Next PC from the architectural rules, using weighted bit fields.
  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [1:0] src,
                                          input logic [19:0] i20, input logic [11:0] i12,
                                          input logic [31:0] base, input logic taken);
    longint off;
    logic [31:0] r;
    case (src)
      2'd1: begin
        off = longint'(i20[7:0]) * 4096 + longint'(i20[8]) * 2048
            + longint'(i20[18:9]) * 2 - (i20[19] ? 1048576 : 0);
        r = pc + off[31:0];
      end
      2'd2: begin
        off = longint'(base) + longint'(i12) - (i12[11] ? 4096 : 0);
        r = off[31:0];
        r[0] = 1'b0;
      end
      2'd3: begin
        if (taken) begin
          off = longint'(i12[4:1]) * 2 + longint'(i12[10:5]) * 32
              + longint'(i12[0]) * 2048 - (i12[11] ? 4096 : 0);
          r = pc + off[31:0];
        end else begin
          r = pc + 32'd4;
        end
      end
      default: r = pc + 32'd4;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.iwImemAck  = 1'b0;
    bus.iwAdvance  = 1'b0;
    bus.iwImemData = $urandom;
    scramble();
    repeat (2) @(negedge clk);
    chk("rst_req", bus.orImemReq, 1'b0);
    chk("rst_addr", bus.orImemAddr, RST_PC);
    chk("rst_instr", bus.orInstr, NOP);
    chk("rst_pc", bus.orPc, RST_PC);
    chk("rst_valid", bus.orInstrValid, 1'b0);
    chk("rst_fault", bus.orFault, 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fetch(input int dly, input logic [31:0] d, input logic [31:0] exp_addr,
                          output int waited);
    waited = 0;
    while (bus.orImemReq !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_high", bus.orImemReq, 1'b1);
    for (int k = 0; k < dly; k++) begin
      chk("addr_hold", bus.orImemAddr, exp_addr);
      chk("req_hold", bus.orImemReq, 1'b1);
      chk("valid_low", bus.orInstrValid, 1'b0);
      bus.iwAdvance = 1'($urandom);
      @(negedge clk);
      bus.iwAdvance = 1'b0;
    end
    chk("addr", bus.orImemAddr, exp_addr);
    bus.iwImemAck  = 1'b1;
    bus.iwImemData = d;
    @(negedge clk);
    bus.iwImemAck  = 1'b0;
    bus.iwImemData = $urandom;
    chk("valid", bus.orInstrValid, 1'b1);
    chk("instr", bus.orInstr, d);
    chk("pc", bus.orPc, exp_addr);
    chk("req_drop", bus.orImemReq, 1'b0);
  endtask

  task automatic do_advance(input int hold, input logic [31:0] d, input logic [31:0] p,
                            input logic [1:0] src, input logic [19:0] i20, input logic [11:0] i12,
                            input logic [31:0] base, input logic taken);
    for (int k = 0; k < hold; k++) begin
      chk("hold_valid", bus.orInstrValid, 1'b1);
      chk("hold_instr", bus.orInstr, d);
      chk("hold_pc", bus.orPc, p);
      bus.iwImemAck  = 1'($urandom);
      bus.iwImemData = $urandom;
      @(negedge clk);
      bus.iwImemAck = 1'b0;
    end
    bus.iwAdvance           = 1'b1;
    bus.iwNextPcSrc         = src;
    bus.iwNextPcImmediate20 = i20;
    bus.iwNextPcImmediate12 = i12;
    bus.iwJalrBase          = base;
    bus.iwBranchTaken       = taken;
    @(negedge clk);
    bus.iwAdvance = 1'b0;
    scramble();
  endtask

  task automatic check_after(input logic [31:0] exp_addr, input logic exp_fault);
    chk("adv_valid", bus.orInstrValid, 1'b0);
    chk("adv_fault", bus.orFault, exp_fault);
    chk("adv_instr", bus.orInstr, NOP);
    if (exp_fault) begin
      chk("fault_req", bus.orImemReq, 1'b0);
    end else begin
      chk("adv_req", bus.orImemReq, 1'b1);
      chk("adv_addr", bus.orImemAddr, exp_addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur;
    logic [31:0] d;
    logic [31:0] nx;
    logic [1:0]  src;
    logic [19:0] i20;
    logic [11:0] i12;
    logic [31:0] base;
    logic        taken;
    int          w;

    tbl[0] = '{2'd2, 20'h0, 12'h000, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    tbl[1] = '{2'd0, 20'h0, 12'h000, 32'h0,         1'b0, 32'h0000_0000, 1'b0};
    tbl[2] = '{2'd2, 20'h0, 12'h000, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0};
    tbl[3] = '{2'd1, 20'h01000, 12'h000, 32'h0,     1'b0, 32'h0000_0110, 1'b0};
    tbl[4] = '{2'd2, 20'h0, 12'h000, 32'h0000_0200, 1'b0, 32'h0000_0200, 1'b0};
    tbl[5] = '{2'd3, 20'h0, 12'hFF9, 32'h0,         1'b1, 32'h0000_01F8, 1'b0};
    tbl[6] = '{2'd2, 20'h0, 12'h000, 32'h0000_0200, 1'b0, 32'h0000_0200, 1'b0};
    tbl[7] = '{2'd3, 20'h0, 12'hFF9, 32'h0,         1'b0, 32'h0000_0204, 1'b0};
    tbl[8] = '{2'd2, 20'h0, 12'hFFF, 32'h0000_1001, 1'b0, 32'h0000_1000, 1'b0};
    tbl[9] = '{2'd2, 20'h0, 12'h004, 32'h0000_1003, 1'b0, 32'h0000_1006, 1'b1};

    // Reset release, ack delay 2: address held for three request cycles.
    do_reset();
    do_fetch(2, 32'h0050_0093, RST_PC, w);
    chk("req_rise_latency", 32'(w), 32'd0);

    // Directed redirect table, each entry starting from the previous target.
    cur = RST_PC;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        d = $urandom;
        do_fetch(int'($urandom_range(0, 3)), d, cur, w);
      end else begin
        d = 32'h0050_0093;
      end
      do_advance(int'($urandom_range(0, 2)), d, cur, tbl[i].src, tbl[i].i20, tbl[i].i12,
                 tbl[i].base, tbl[i].taken);
      check_after(tbl[i].exp_addr, tbl[i].exp_fault);
      cur = tbl[i].exp_addr;
    end

    // Fault is sticky: stray acks/advances must not restart fetching.
    for (int k = 0; k < 10; k++) begin
      bus.iwImemAck  = 1'($urandom);
      bus.iwAdvance  = 1'($urandom);
      bus.iwImemData = $urandom;
      scramble();
      @(negedge clk);
      chk("sticky_req", bus.orImemReq, 1'b0);
      chk("sticky_fault", bus.orFault, 1'b1);
      chk("sticky_valid", bus.orInstrValid, 1'b0);
    end
    bus.iwImemAck = 1'b0;
    bus.iwAdvance = 1'b0;

    // Async reset during a request, colliding with an ack.
    do_reset();
    @(negedge clk);
    chk("midrst_req_pre", bus.orImemReq, 1'b1);
    bus.iwImemAck  = 1'b1;
    bus.iwImemData = 32'hDEAD_BEEF;
    rst = 1'b1;
    #1;
    chk("midrst_req_drop", bus.orImemReq, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_valid", bus.orInstrValid, 1'b0);
    chk("midrst_instr", bus.orInstr, NOP);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.iwImemAck = 1'b0;
    do_fetch(1, 32'h1234_5677, RST_PC, w);

    // Randomized run against the reference model.
    cur = RST_PC;
    d   = 32'h1234_5677;
    for (int n = 0; n < 60; n++) begin
      src   = 2'($urandom);
      i20   = 20'($urandom);
      i12   = 12'($urandom);
      base  = $urandom;
      taken = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        i20[9] = 1'b0;
        i12[1] = 1'b0;
        base[1:0] = 2'b00;
        i12[1:0]  = 2'b00;
      end
      nx = ref_npc(cur, src, i20, i12, base, taken);
      do_advance(int'($urandom_range(0, 2)), d, cur, src, i20, i12, base, taken);
      check_after(nx, nx[1:0] != 2'b00);
      if (nx[1:0] != 2'b00) begin
        do_reset();
        cur = RST_PC;
      end else begin
        cur = nx;
      end
      d = $urandom;
      do_fetch(int'($urandom_range(0, 3)), d, cur, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_rv.md
Name: instr_fetch_rv

Overview:
- RV32I fetch stage sitting directly upstream of the instruction decoder.
- Holds the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents {instruction, PC} to decode and holds them until the downstream stage advances.
- On advance, computes the next PC from the decoder/execute redirect fields (NEXT_PC_SRC_* encoding, raw J/B immediate bit fields) and flags misaligned targets.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset; must be 4-byte aligned.
- NOP_INSTR, 32'h00000013, value driven on orInstr while no valid instruction is held (addi x0,x0,0).

Ports:
- iwClk  in  1  clock, rising edge.
- iwRst  in  1  reset, asynchronous, active-high.
- orImemReq  out  1  fetch request.
- orImemAddr  out  32  fetch address (word aligned).
- iwImemAck  in  1  memory returns data this cycle.
- iwImemData  in  32  instruction word, sampled only when orImemReq && iwImemAck.
- orInstr  out  32  instruction to decode.
- orPc  out  32  PC of orInstr.
- orInstrValid  out  1  orInstr/orPc valid.
- iwAdvance  in  1  downstream consumes the current instruction; redirect inputs are valid this cycle.
- iwNextPcSrc  in  2  NEXT_PC_SRC_SEQ/JAL/JALR/B.
- iwNextPcImmediate20  in  20  raw instr[31:12].
- iwNextPcImmediate12  in  12  raw instr[31:20] for JALR; {instr[31:25], instr[11:7]} for B.
- iwJalrBase  in  32  rs1 value for JALR.
- iwBranchTaken  in  1  resolved branch condition, with inversion already applied.
- orFault  out  1  sticky misaligned-target fault.

Behaviour:
- Reset (async, iwRst=1) sets:
  - state=S_IDLE, PC=RESET_PC
  - orImemReq=0, orImemAddr=RESET_PC
  - orInstr=NOP_INSTR, orPc=RESET_PC, orInstrValid=0, orFault=0
- States and transitions:
  - S_IDLE: one cycle after reset release, then S_REQ.
  - S_REQ: drive orImemReq=1 and orImemAddr=PC; hold both stable until iwImemAck. On ack, register orInstr=iwImemData and orPc=PC, then go to S_VALID. Ack latency is unbounded; ack is allowed in the first S_REQ cycle.
  - S_VALID: orInstrValid=1 and orImemReq=0; orInstr and orPc are held stable. On iwAdvance, compute NPC:
    - NPC[1:0]!=0: go to S_FAULT.
    - Otherwise: PC=NPC, orInstrValid=0, orInstr=NOP_INSTR, go to S_REQ.
  - S_FAULT: orFault=1, orInstrValid=0, orImemReq=0; leave only via reset.
- NPC computation (all arithmetic modulo 2^32, wrap-around permitted):
  - SEQ: PC+4.
  - JAL: PC + sext({i20[19], i20[7:0], i20[8], i20[18:9], 1'b0}), 21-bit offset.
  - JALR: (iwJalrBase + sext(i12)) & ~32'h1. Alignment is checked after the bit-0 clear.
  - B: iwBranchTaken ? PC + sext({i12[11], i12[0], i12[10:5], i12[4:1], 1'b0}) : PC+4.
- Latency:
  - Ack in cycle N → orInstrValid=1 in cycle N+1.
  - Advance in cycle M → orImemReq=1 with the new address in cycle M+1.
  - Best case: one instruction per 2 cycles (no overlap by design).
- Ignored inputs:
  - iwImemAck outside S_REQ is ignored.
  - iwAdvance outside S_VALID is ignored.
  - Redirect inputs are sampled only in the advance cycle.
- Reset mid-fetch: the request drops immediately (async); an ack arriving while iwRst=1, or in S_IDLE, is discarded.

Test Plan:
- Reset release with ack delay 2: orImemReq rises 1 cycle after release with orImemAddr=0x0 held for 3 cycles; on ack, data 0x00500093 → orInstr=0x00500093, orPc=0, orInstrValid=1 next cycle.
- SEQ wrap: PC=0xFFFFFFFC, advance with SEQ → orImemAddr=0x00000000, orFault=0.
- JAL: PC=0x100, i20=0x01000 (jal +16) → next fetch 0x110.
- Branch: PC=0x200, B, i12=0xFF9 (−8):
  - taken → 0x1F8
  - not taken → 0x204
- JALR:
  - base 0x1001, i12=0xFFF → 0x1000.
  - base 0x1003, i12=0x004 → 0x1006 misaligned → orFault=1, orImemReq stays 0 through 10 cycles of stray acks/advances.
- Async reset asserted during S_REQ with ack in the same cycle → orInstrValid stays 0, orInstr=NOP_INSTR; after release, refetch from RESET_PC.
